// File: rtl/disp_scan_if.sv
// disp_scan_if
//   Bundles the signals between a display scan controller and whoever owns the
//   display word.
//   master : drives en/dat, observes adr/an/scan_tick/state
//   slave  : the scan controller itself
// Signals
//   en        scan enable (level, no handshake: the controller never stalls the
//             source and the source never waits on the controller)
//   dat[15:0] display word, digit k = dat[4k+3:4k]
//   adr[1:0]  digit select to the nibble mux
//   an[3:0]   active-low anode enables
//   scan_tick one-cycle pulse in the cycle adr has just advanced
//   state     FSM state, debug visibility only
interface disp_scan_if;
  logic        en;
  logic [15:0] dat;
  logic [1:0]  adr;
  logic [3:0]  an;
  logic        scan_tick;
  logic [1:0]  state;

  modport master (
    output en, dat,
    input  adr, an, scan_tick, state
  );

  modport slave (
    input  en, dat,
    output adr, an, scan_tick, state
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Scan controller for a 4-digit multiplexed 7-segment display. Steps a 2-bit
//   digit address through 0..3, one slot of DIV clocks per digit. Each slot
//   starts with BLANK clocks of all anodes off (anti-ghosting), then lights the
//   addressed digit for the rest of the slot. Optional leading-zero blanking.
// Parameters
//   DIV    clocks per digit slot, DIV >= BLANK+2
//   BLANK  dark clocks at the start of each slot, BLANK >= 1
//   LZB_EN 1 = blank leading-zero digits, 0 = light all four
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   bus    disp_scan_if.slave: en/dat in; adr/an/scan_tick/state out
//          (all outputs registered)
module disp_scan_ctrl #(
  parameter int DIV    = 50000,
  parameter int BLANK  = 16,
  parameter bit LZB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  disp_scan_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] BLANK_CNT  = CW'(BLANK);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    adr;
  logic [3:0]    an;
  logic          scan_tick;
  logic [3:0]    show_mask;

  // Anode pattern for the current digit, evaluated from dat as it stands.
  // It is only captured into an at the BLANK->SHOW edge, so a dat change
  // mid-slot does not disturb the lit digit.
  always_comb begin
    show_mask = ~(4'b0001 << adr);
    if (LZB_EN) begin
      case (adr)
        2'd1:    if (bus.dat[15:4]  == 12'h000) show_mask = 4'hF;
        2'd2:    if (bus.dat[15:8]  == 8'h00)   show_mask = 4'hF;
        2'd3:    if (bus.dat[15:12] == 4'h0)    show_mask = 4'hF;
        default: ;  // digit 0 is always lit so an all-zero word shows "0"
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      adr       <= 2'd0;
      an        <= 4'hF;
      scan_tick <= 1'b0;
    end else if (!bus.en) begin
      // Display dark and scan frozen; adr is held so the scan resumes where
      // it stopped.
      state     <= S_IDLE;
      cnt       <= '0;
      an        <= 4'hF;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_BLANK;
          cnt   <= '0;
          an    <= 4'hF;
        end
        S_BLANK: begin
          an <= 4'hF;
          if (cnt == BLANK_LAST) begin
            state <= S_SHOW;
            cnt   <= BLANK_CNT;
            an    <= show_mask;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_SHOW: begin
          if (cnt == DIV_LAST) begin
            // adr moves only here, so it is stable through the following
            // blank window while the mux and decoder settle.
            state     <= S_BLANK;
            cnt       <= '0;
            adr       <= adr + 2'd1;
            an        <= 4'hF;
            scan_tick <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          an    <= 4'hF;
        end
      endcase
    end
  end

  assign bus.state     = state;
  assign bus.adr       = adr;
  assign bus.an        = an;
  assign bus.scan_tick = scan_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int W     = 13;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  disp_scan_if bus ();
  disp_scan_if bus2 ();

  disp_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .LZB_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Second instance without leading-zero blanking, fed identical stimulus.
  disp_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .LZB_EN(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic        en;
    logic [15:0] dat;
    logic [1:0]  st;
    logic [1:0]  adr;
    logic [3:0]  an;
    logic        tick;
    logic [3:0]  an2;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             total = 0;
  int             bad   = 0;

  // Anode pattern for digit a of word d: one low bit, or all high if the digit
  // is a leading zero (digits 1..3 only).
  function automatic logic [3:0] ref_mask(logic [1:0] a, logic [15:0] d, bit lzb);
    logic [3:0] m;
    m    = 4'hF;
    m[a] = 1'b0;
    if (lzb && a != 2'd0 && (d >> (4 * a)) == 16'h0000) m = 4'hF;
    return m;
  endfunction

  function automatic vec_t idle_vec(logic [1:0] a, logic [15:0] d);
    vec_t v;
    v.en = 1'b0; v.dat = d; v.st = ST_IDLE; v.adr = a;
    v.an = 4'hF; v.tick = 1'b0; v.an2 = 4'hF;
    return v;
  endfunction

  // Expected outputs after the j-th enabled edge (j=1 is the IDLE->BLANK edge),
  // from slot arithmetic: slot s = (j-1)/DIV, position in slot = (j-1)%DIV.
  // lat is the word seen at the start of the lit part of the slot.
  function automatic vec_t model(int j, logic [1:0] a0, logic [15:0] lat);
    vec_t v;
    int   pos;
    int   s;
    pos    = (j - 1) % DIV;
    s      = (j - 1) / DIV;
    v.en   = 1'b1;
    v.dat  = lat;
    v.adr  = a0 + 2'(s);
    v.tick = (pos == 0 && s > 0);
    if (pos < BLANK) begin
      v.st = ST_BLANK; v.an = 4'hF; v.an2 = 4'hF;
    end else begin
      v.st  = ST_SHOW;
      v.an  = ref_mask(v.adr, lat, 1'b1);
      v.an2 = ref_mask(v.adr, lat, 1'b0);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] pk(vec_t v);
    return {v.st, v.adr, v.an, v.tick, v.an2};
  endfunction

  task automatic check(input string name);
    logic [W-1:0] ex;
    logic [W-1:0] act;
    ex  = exp_q.pop_front();
    act = {bus.state, bus.adr, bus.an, bus.scan_tick, bus2.an};
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got st=%0d adr=%0d an=%b tick=%b an2=%b, want st=%0d adr=%0d an=%b tick=%b an2=%b",
               name, act[12:11], act[10:9], act[8:5], act[4], act[3:0],
               ex[12:11], ex[10:9], ex[8:5], ex[4], ex[3:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic [15:0] dat, input vec_t e, input string name);
    @(negedge clk);
    bus.en   = en;
    bus.dat  = dat;
    bus2.en  = en;
    bus2.dat = dat;
    exp_q.push_back(pk(e));
    @(posedge clk);
    #1;
    check(name);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] segd[5];
    logic [15:0] d;
    logic [15:0] lat;
    int          pos;

    segd[0] = 16'h1234;
    segd[1] = 16'h0050;
    segd[2] = 16'h0000;
    segd[3] = 16'h0007;
    segd[4] = 16'($urandom_range(16'h0001, 16'hFFFF));

    // Each segment: one disabled edge (adr held), then 33 enabled edges
    // covering a full frame plus the wrap back to adr 0.
    for (int s = 0; s < 5; s++) begin
      vecs.push_back(idle_vec(2'd0, segd[s]));
      for (int j = 1; j <= 4 * DIV + 1; j++) vecs.push_back(model(j, 2'd0, segd[s]));
    end

    bus.en = 1'b0;  bus.dat = 16'h0000;
    bus2.en = 1'b0; bus2.dat = 16'h0000;

    // reset values, checked before any clock edge
    #1 rst = 1'b1;
    #2;
    exp_q.push_back(pk(idle_vec(2'd0, 16'h0000)));
    check("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // table: frames with 1234, 0050, 0000 (also exercises LZB_EN=0), 0007, random
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].en, vecs[i].dat, vecs[i], $sformatf("vec%0d", i));

    // en dropped mid-SHOW at adr 2, then resumed
    step(1'b0, 16'h1234, idle_vec(2'd0, 16'h1234), "t4_pre");
    for (int j = 1; j <= 2 * DIV + BLANK + 2; j++)
      step(1'b1, 16'h1234, model(j, 2'd0, 16'h1234), $sformatf("t4_run%0d", j));
    step(1'b0, 16'h1234, idle_vec(2'd2, 16'h1234), "t4_stop");
    step(1'b0, 16'h1234, idle_vec(2'd2, 16'h1234), "t4_hold");
    for (int j = 1; j <= BLANK + 4; j++)
      step(1'b1, 16'h1234, model(j, 2'd2, 16'h1234), $sformatf("t4_resume%0d", j));

    // asynchronous reset pulse between edges, mid-SHOW
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(pk(idle_vec(2'd0, 16'h1234)));
    check("t5_async");
    rst = 1'b0;

    // dat changes during SHOW only take effect at the digit's next slot
    lat = 16'h0000;
    for (int j = 1; j <= 5 * DIV + BLANK + 2; j++) begin
      if (j < 4)       d = 16'h0000;
      else if (j < 31) d = 16'hF000;
      else             d = 16'h0000;
      pos = (j - 1) % DIV;
      if (pos == BLANK) lat = d;
      step(1'b1, d, model(j, 2'd0, lat), $sformatf("t6_j%0d", j));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
